mips_pipe_control: RTL

Pipelined control unit for the 5-stage MIPS core. It decodes the decode-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers, together with register addresses. It detects load-use and decode-branch hazards and generates the stall, flush and redirect signals for the datapath. The instruction set is parametrised: base set lw/sw/R-type/addi/beq/j, with an optional bne/andi/ori/slti extension.

---
 rtl/mips_pipe_control_if.sv | 66 ++++++
 rtl/mips_pipe_control.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_control_if.sv
// rtl/mips_pipe_control_if.sv - decode-side and pipeline-control bundle for mips_pipe_control
//
// Purpose: groups the decode-stage inputs and every control/hazard output of
// the pipelined MIPS control unit into one bundle.
// Ports (by modport):
//   slave  (control unit): in  Opcode_D, Rs_D, Rt_D, Rd_D, Equal_D, Hold
//                          out Jump_D, PCSrc_D, ZeroExt_D, Stall_F, Stall_D,
//                              Flush_D, Flush_E, ALUOp_E, ALUSrc_E, RegDst_E,
//                              RegWrite_E, MemtoReg_E, Rs_E, Rt_E, WriteReg_E,
//                              MemWrite_M, RegWrite_M, MemtoReg_M, WriteReg_M,
//                              RegWrite_W, MemtoReg_W, WriteReg_W
//   master (datapath/bench): the same signals with directions reversed
interface mips_pipe_control_if #(
  parameter int ADDR_W = 5
);
  logic [5:0]        Opcode_D;
  logic [ADDR_W-1:0] Rs_D;
  logic [ADDR_W-1:0] Rt_D;
  logic [ADDR_W-1:0] Rd_D;
  logic              Equal_D;
  logic              Hold;

  logic              Jump_D;
  logic              PCSrc_D;
  logic              ZeroExt_D;
  logic              Stall_F;
  logic              Stall_D;
  logic              Flush_D;
  logic              Flush_E;

  logic [2:0]        ALUOp_E;
  logic              ALUSrc_E;
  logic              RegDst_E;
  logic              RegWrite_E;
  logic              MemtoReg_E;
  logic [ADDR_W-1:0] Rs_E;
  logic [ADDR_W-1:0] Rt_E;
  logic [ADDR_W-1:0] WriteReg_E;

  logic              MemWrite_M;
  logic              RegWrite_M;
  logic              MemtoReg_M;
  logic [ADDR_W-1:0] WriteReg_M;

  logic              RegWrite_W;
  logic              MemtoReg_W;
  logic [ADDR_W-1:0] WriteReg_W;

  modport slave (
    input  Opcode_D, Rs_D, Rt_D, Rd_D, Equal_D, Hold,
    output Jump_D, PCSrc_D, ZeroExt_D, Stall_F, Stall_D, Flush_D, Flush_E,
           ALUOp_E, ALUSrc_E, RegDst_E, RegWrite_E, MemtoReg_E,
           Rs_E, Rt_E, WriteReg_E,
           MemWrite_M, RegWrite_M, MemtoReg_M, WriteReg_M,
           RegWrite_W, MemtoReg_W, WriteReg_W
  );

  modport master (
    output Opcode_D, Rs_D, Rt_D, Rd_D, Equal_D, Hold,
    input  Jump_D, PCSrc_D, ZeroExt_D, Stall_F, Stall_D, Flush_D, Flush_E,
           ALUOp_E, ALUSrc_E, RegDst_E, RegWrite_E, MemtoReg_E,
           Rs_E, Rt_E, WriteReg_E,
           MemWrite_M, RegWrite_M, MemtoReg_M, WriteReg_M,
           RegWrite_W, MemtoReg_W, WriteReg_W
  );
endinterface

// File: rtl/mips_pipe_control.sv
// rtl/mips_pipe_control.sv - pipelined decode, hazard detection and control registers for a 5-stage MIPS
//
// Purpose: decodes the D-stage opcode, carries the control bundle through the
// ID/EX, EX/MEM and MEM/WB registers, and raises stall/flush/redirect for
// load-use and decode-branch hazards.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset of all pipeline registers
//   bus  - mips_pipe_control_if.slave (decode inputs, hazard and stage controls)
// Parameters:
//   EXT_OPS - 1 enables bne/andi/ori/slti decode
//   ADDR_W  - register address width
module mips_pipe_control #(
  parameter bit EXT_OPS = 1'b1,
  parameter int ADDR_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  mips_pipe_control_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // decode-stage control bundle
  logic       w_reg_write_d;
  logic       w_mem_to_reg_d;
  logic       w_mem_write_d;
  logic [2:0] w_alu_op_d;
  logic       w_alu_src_d;
  logic       w_reg_dst_d;
  logic       w_branch_d;
  logic       w_branch_ne_d;
  logic       w_jump_d;
  logic       w_zero_ext_d;

  // ID/EX
  logic              r_reg_write_e;
  logic              r_mem_to_reg_e;
  logic              r_mem_write_e;
  logic [2:0]        r_alu_op_e;
  logic              r_alu_src_e;
  logic              r_reg_dst_e;
  logic [ADDR_W-1:0] r_rs_e;
  logic [ADDR_W-1:0] r_rt_e;
  logic [ADDR_W-1:0] r_rd_e;

  // EX/MEM
  logic              r_reg_write_m;
  logic              r_mem_to_reg_m;
  logic              r_mem_write_m;
  logic [ADDR_W-1:0] r_write_reg_m;

  // MEM/WB
  logic              r_reg_write_w;
  logic              r_mem_to_reg_w;
  logic [ADDR_W-1:0] r_write_reg_w;

  logic [ADDR_W-1:0] w_write_reg_e;
  logic              w_e_hit;
  logic              w_m_hit;
  logic              w_lw_stall;
  logic              w_br_stall;
  logic              w_stall;
  logic              w_flush_e;
  logic              w_pc_src;
  logic              w_jump_taken;

  always_comb begin
    w_reg_write_d  = 1'b0;
    w_mem_to_reg_d = 1'b0;
    w_mem_write_d  = 1'b0;
    w_alu_op_d     = ALU_ADD;
    w_alu_src_d    = 1'b0;
    w_reg_dst_d    = 1'b0;
    w_branch_d     = 1'b0;
    w_branch_ne_d  = 1'b0;
    w_jump_d       = 1'b0;
    w_zero_ext_d   = 1'b0;
    case (bus.Opcode_D)
      OP_LW: begin
        w_reg_write_d  = 1'b1;
        w_mem_to_reg_d = 1'b1;
        w_alu_src_d    = 1'b1;
      end
      OP_SW: begin
        w_mem_write_d = 1'b1;
        w_alu_src_d   = 1'b1;
      end
      OP_RTYPE: begin
        w_reg_write_d = 1'b1;
        w_reg_dst_d   = 1'b1;
        w_alu_op_d    = ALU_FUNCT;
      end
      OP_ADDI: begin
        w_reg_write_d = 1'b1;
        w_alu_src_d   = 1'b1;
      end
      OP_BEQ: begin
        w_branch_d = 1'b1;
        w_alu_op_d = ALU_SUB;
      end
      OP_J: w_jump_d = 1'b1;
      OP_BNE: begin
        if (EXT_OPS) begin
          w_branch_ne_d = 1'b1;
          w_alu_op_d    = ALU_SUB;
        end
      end
      OP_ANDI: begin
        if (EXT_OPS) begin
          w_reg_write_d = 1'b1;
          w_alu_src_d   = 1'b1;
          w_zero_ext_d  = 1'b1;
          w_alu_op_d    = ALU_AND;
        end
      end
      OP_ORI: begin
        if (EXT_OPS) begin
          w_reg_write_d = 1'b1;
          w_alu_src_d   = 1'b1;
          w_zero_ext_d  = 1'b1;
          w_alu_op_d    = ALU_OR;
        end
      end
      OP_SLTI: begin
        if (EXT_OPS) begin
          w_reg_write_d = 1'b1;
          w_alu_src_d   = 1'b1;
          w_alu_op_d    = ALU_SLT;
        end
      end
      default: ;
    endcase
  end

  assign w_write_reg_e = r_reg_dst_e ? r_rd_e : r_rt_e;

  // A producer targeting $0 never matches, so writes to $0 cannot stall.
  assign w_e_hit = (w_write_reg_e != '0) &&
                   ((w_write_reg_e == bus.Rs_D) || (w_write_reg_e == bus.Rt_D));
  assign w_m_hit = (r_write_reg_m != '0) &&
                   ((r_write_reg_m == bus.Rs_D) || (r_write_reg_m == bus.Rt_D));

  assign w_lw_stall = r_mem_to_reg_e & r_reg_write_e & w_e_hit;
  // Branches compare in D, so they must also wait for an ALU result in E
  // and for a load result still in M.
  assign w_br_stall = (w_branch_d | w_branch_ne_d) &
                      ((r_reg_write_e & w_e_hit) | (r_mem_to_reg_m & w_m_hit));
  assign w_stall    = w_lw_stall | w_br_stall;

  // Hold wins over hazards: nothing is bubbled or redirected while frozen.
  assign w_flush_e    = w_stall & ~bus.Hold;
  assign w_pc_src     = ~w_stall & ((w_branch_d & bus.Equal_D) |
                                    (w_branch_ne_d & ~bus.Equal_D));
  assign w_jump_taken = w_jump_d & ~w_stall;

  assign bus.Stall_F   = w_stall | bus.Hold;
  assign bus.Stall_D   = w_stall | bus.Hold;
  assign bus.Flush_E   = w_flush_e;
  assign bus.PCSrc_D   = w_pc_src;
  assign bus.Jump_D    = w_jump_taken;
  assign bus.Flush_D   = (w_pc_src | w_jump_taken) & ~bus.Hold;
  assign bus.ZeroExt_D = w_zero_ext_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write_e  <= 1'b0;
      r_mem_to_reg_e <= 1'b0;
      r_mem_write_e  <= 1'b0;
      r_alu_op_e     <= ALU_ADD;
      r_alu_src_e    <= 1'b0;
      r_reg_dst_e    <= 1'b0;
      r_rs_e         <= '0;
      r_rt_e         <= '0;
      r_rd_e         <= '0;
      r_reg_write_m  <= 1'b0;
      r_mem_to_reg_m <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_write_reg_m  <= '0;
      r_reg_write_w  <= 1'b0;
      r_mem_to_reg_w <= 1'b0;
      r_write_reg_w  <= '0;
    end else if (!bus.Hold) begin
      r_reg_write_w  <= r_reg_write_m;
      r_mem_to_reg_w <= r_mem_to_reg_m;
      r_write_reg_w  <= r_write_reg_m;
      r_reg_write_m  <= r_reg_write_e;
      r_mem_to_reg_m <= r_mem_to_reg_e;
      r_mem_write_m  <= r_mem_write_e;
      r_write_reg_m  <= w_write_reg_e;
      if (w_flush_e) begin
        r_reg_write_e  <= 1'b0;
        r_mem_to_reg_e <= 1'b0;
        r_mem_write_e  <= 1'b0;
        r_alu_op_e     <= ALU_ADD;
        r_alu_src_e    <= 1'b0;
        r_reg_dst_e    <= 1'b0;
        r_rs_e         <= '0;
        r_rt_e         <= '0;
        r_rd_e         <= '0;
      end else begin
        r_reg_write_e  <= w_reg_write_d;
        r_mem_to_reg_e <= w_mem_to_reg_d;
        r_mem_write_e  <= w_mem_write_d;
        r_alu_op_e     <= w_alu_op_d;
        r_alu_src_e    <= w_alu_src_d;
        r_reg_dst_e    <= w_reg_dst_d;
        r_rs_e         <= bus.Rs_D;
        r_rt_e         <= bus.Rt_D;
        r_rd_e         <= bus.Rd_D;
      end
    end
  end

  assign bus.ALUOp_E    = r_alu_op_e;
  assign bus.ALUSrc_E   = r_alu_src_e;
  assign bus.RegDst_E   = r_reg_dst_e;
  assign bus.RegWrite_E = r_reg_write_e;
  assign bus.MemtoReg_E = r_mem_to_reg_e;
  assign bus.Rs_E       = r_rs_e;
  assign bus.Rt_E       = r_rt_e;
  assign bus.WriteReg_E = w_write_reg_e;

  assign bus.MemWrite_M = r_mem_write_m;
  assign bus.RegWrite_M = r_reg_write_m;
  assign bus.MemtoReg_M = r_mem_to_reg_m;
  assign bus.WriteReg_M = r_write_reg_m;

  assign bus.RegWrite_W = r_reg_write_w;
  assign bus.MemtoReg_W = r_mem_to_reg_w;
  assign bus.WriteReg_W = r_write_reg_w;

endmodule
